// File: rtl/soft_max.sv
// rtl/soft_max.sv - two-stage argmax over LAYER_SIZE signed scores (softmax classification stage)
module soft_max #(
  parameter int WORD_SIZE  = 16,
  parameter int LAYER_SIZE = 10
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  input  logic signed [WORD_SIZE-1:0]         X [LAYER_SIZE],
  output logic                                out_valid,
  output logic [$clog2(LAYER_SIZE)-1:0]       Z,
  output logic signed [WORD_SIZE-1:0]         Z_max
);

  localparam int IW     = $clog2(LAYER_SIZE);
  localparam int LEVELS = $clog2(LAYER_SIZE);

  logic signed [WORD_SIZE-1:0] X_q [LAYER_SIZE];
  logic                        v1;

  // One extra slot keeps the pair read of an odd-sized level in range.
  logic signed [WORD_SIZE-1:0] tv [LAYER_SIZE+1];
  logic [IW-1:0]               ti [LAYER_SIZE+1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1 <= 1'b0;
      for (int k = 0; k < LAYER_SIZE; k++) X_q[k] <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        for (int k = 0; k < LAYER_SIZE; k++) X_q[k] <= X[k];
      end
    end
  end

  // Pairwise reduction tree, done in place: level l writes slot j from slots 2j/2j+1.
  // Left operands always carry lower indices, so strict > keeps the lowest index on ties.
  always_comb begin
    int n;
    for (int k = 0; k <= LAYER_SIZE; k++) begin
      tv[k] = '0;
      ti[k] = '0;
    end
    for (int k = 0; k < LAYER_SIZE; k++) begin
      tv[k] = X_q[k];
      ti[k] = IW'(k);
    end
    n = LAYER_SIZE;
    for (int l = 0; l < LEVELS; l++) begin
      for (int j = 0; j < (LAYER_SIZE + 1) / 2; j++) begin
        if (2 * j + 1 < n) begin
          if (tv[2*j+1] > tv[2*j]) begin
            tv[j] = tv[2*j+1];
            ti[j] = ti[2*j+1];
          end else begin
            tv[j] = tv[2*j];
            ti[j] = ti[2*j];
          end
        end else if (2 * j < n) begin
          tv[j] = tv[2*j];
          ti[j] = ti[2*j];
        end
      end
      n = (n + 1) / 2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      Z         <= '0;
      Z_max     <= '0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        Z     <= ti[0];
        Z_max <= tv[0];
      end
    end
  end

endmodule

// File: tb/tb_soft_max.sv
// tb/tb_soft_max.sv - directed and random checks of the soft_max argmax pipeline
module tb_soft_max;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic signed [15:0] x [10];
  logic               out_valid;
  logic [3:0]         z;
  logic signed [15:0] z_max;

  int checks;
  int failures;

  soft_max #(.WORD_SIZE(16), .LAYER_SIZE(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .X        (x),
    .out_valid(out_valid),
    .Z        (z),
    .Z_max    (z_max)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic signed [15:0] v);
    for (int i = 0; i < 10; i++) x[i] = v;
  endtask

  // Send one vector, then expect it on the outputs after the second edge.
  task automatic send_check(input string tag, input logic [3:0] ez, input logic [15:0] em);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    fill(16'sh1234);
    step();
    check({tag, "_valid"}, 16'(out_valid), 16'd1);
    check({tag, "_z"}, 16'(z), 16'(ez));
    check({tag, "_zmax"}, 16'(z_max), em);
  endtask

  function automatic int ref_argmax(input logic signed [15:0] v [10]);
    int best = 0;
    for (int i = 1; i < 10; i++) if (v[i] > v[best]) best = i;
    return best;
  endfunction

  initial begin
    logic signed [15:0] sv [10];
    int                 ri;
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    in_valid = 1'b0;
    fill(16'sh0);

    // 1. reset
    step();
    step();
    check("rst_valid", 16'(out_valid), 16'd0);
    check("rst_z", 16'(z), 16'd0);
    check("rst_zmax", 16'(z_max), 16'h0000);
    reset = 1'b1;
    step();
    step();
    check("rel_valid", 16'(out_valid), 16'd0);

    // 2. all-negative with three-way tie
    x[0] = 16'shAABF; x[1] = 16'shAAB7; x[2] = 16'shAAB7; x[3] = 16'shAAAF; x[4] = 16'shAABF;
    x[5] = 16'shAABB; x[6] = 16'shAABF; x[7] = 16'shAA9F; x[8] = 16'shAAAF; x[9] = 16'shAAB7;
    send_check("neg", 4'd0, 16'hAABF);

    // 3. sign handling
    fill(16'shFFFF); x[3] = 16'sh0001;
    send_check("sign_a", 4'd3, 16'h0001);
    fill(16'sh0000); x[7] = 16'sh7FFF; x[2] = 16'sh8000;
    send_check("sign_b", 4'd7, 16'h7FFF);
    fill(16'sh8000); x[9] = 16'sh8001;
    send_check("sign_c", 4'd9, 16'h8001);

    // 4. back-to-back streaming
    for (int k = 0; k < 12; k++) begin
      if (k < 10) begin
        for (int i = 0; i < 10; i++) x[i] = 16'(i * 3 - 100);
        x[k] = 16'(500 + k);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (k >= 1 && k <= 10) begin
        check("stream_valid", 16'(out_valid), 16'd1);
        check("stream_z", 16'(z), 16'(k - 1));
        check("stream_zmax", 16'(z_max), 16'(500 + k - 1));
      end
    end
    check("stream_end_valid", 16'(out_valid), 16'd0);

    // 5. bubble and hold
    fill(16'sh0010); x[5] = 16'sh0020;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    fill(16'sh7FFF);
    step();
    check("bub_a_valid", 16'(out_valid), 16'd1);
    check("bub_a_z", 16'(z), 16'd5);
    fill(16'sh0001); x[2] = 16'sh0003;
    in_valid = 1'b1;
    step();
    check("bub_gap_valid", 16'(out_valid), 16'd0);
    check("bub_gap_z", 16'(z), 16'd5);
    check("bub_gap_zmax", 16'(z_max), 16'h0020);
    in_valid = 1'b0;
    step();
    check("bub_b_valid", 16'(out_valid), 16'd1);
    check("bub_b_z", 16'(z), 16'd2);

    // 6. reset with two vectors in flight
    fill(16'sh0000); x[8] = 16'sh0044;
    in_valid = 1'b1;
    step();
    fill(16'sh0000); x[1] = 16'sh0055;
    step();
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 16'(out_valid), 16'd0);
    check("mid_rst_z", 16'(z), 16'd0);
    check("mid_rst_zmax", 16'(z_max), 16'h0000);
    step();
    reset = 1'b1;
    step();
    check("post_rst_valid1", 16'(out_valid), 16'd0);
    step();
    check("post_rst_valid2", 16'(out_valid), 16'd0);

    // random regression, half the vectors drawn from a narrow range to force ties
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 10; i++) begin
        if (t % 2 == 0) sv[i] = 16'($urandom_range(0, 7)) - 16'sd4;
        else            sv[i] = 16'($urandom);
        x[i] = sv[i];
      end
      ri = ref_argmax(sv);
      send_check("rand", 4'(ri), 16'(sv[ri]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
